// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg -- shared state encoding and control-bit indices for the pipeline sequencer.
// rev 1.0
`default_nettype none

package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_MWAIT = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

   localparam int STL_PC     = 0;
   localparam int STL_FI_ID  = 1;
   localparam int STL_ID_EX  = 2;
   localparam int STL_EX_MEM = 3;
   localparam int STL_MEM_WB = 4;

   localparam int BUB_FI_ID  = 0;
   localparam int BUB_ID_EX  = 1;
   localparam int BUB_EX_MEM = 2;
   localparam int BUB_MEM_WB = 3;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_det.sv
// pipe_hazard_det -- load-use comparator between the ID sources and the EX load destination.
// rev 1.0
`default_nettype none

module pipe_hazard_det #(
   parameter int REG_AW = 6
) (
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_regwe,
   input  logic              ex_is_load,
   output logic              load_use
);

   logic rs_hit;
   logic rt_hit;

   always_comb begin
      rs_hit   = id_uses_rs & (id_rs == ex_rd);
      rt_hit   = id_uses_rt & (id_rt == ex_rd);
      // r0 is hardwired, so a load into it never creates a dependency
      load_use = ex_is_load & ex_regwe & (ex_rd != '0) & (rs_hit | rt_hit);
   end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- stall/flush sequencer with memory-wait timeout and halt/drain handshake.
// Optional: PIPE_CTRL_PERF_EN adds perf_stall_cyc/perf_flush_cnt counters. rev 1.0
`default_nettype none

module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW      = 6,
   parameter int MEM_TIMEOUT = 15,
   parameter int DRAIN_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_regwe,
   input  logic              ex_is_load,
   input  logic              br_taken,
   input  logic              mem_req,
   input  logic              mem_ack,
   input  logic              halt_req,
   output logic [4:0]        stall,
   output logic [3:0]        bubble,
   output logic              halt_ack,
   output logic              mem_err
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]       perf_stall_cyc,
   output logic [31:0]       perf_flush_cnt
`endif
);

   localparam int            TW     = $clog2(MEM_TIMEOUT + 1);
   localparam int            DW     = $clog2(DRAIN_DEPTH + 1);
   localparam logic [TW-1:0] TO_MAX = TW'(MEM_TIMEOUT);
   localparam logic [DW-1:0] DR_END = DW'(DRAIN_DEPTH - 1);

   state_e        state_q, state_d;
   logic          ret_q, ret_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic          halt_ack_q, halt_ack_d;
   logic          mem_err_q, mem_err_d;

   logic [4:0]    stall_c;
   logic [3:0]    bubble_c;
   logic          flush_c;
   logic          mem_wait;
   logic          load_use;

   pipe_hazard_det #(
      .REG_AW (REG_AW)
   ) u_hazard (
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rs (id_uses_rs),
      .id_uses_rt (id_uses_rt),
      .ex_rd      (ex_rd),
      .ex_regwe   (ex_regwe),
      .ex_is_load (ex_is_load),
      .load_use   (load_use)
   );

   always_comb begin
      state_d   = state_q;
      ret_d     = ret_q;
      tcnt_d    = tcnt_q;
      dcnt_d    = dcnt_q;
      mem_err_d = mem_err_q;
      stall_c   = '0;
      bubble_c  = '0;
      flush_c   = 1'b0;
      mem_wait  = mem_req & ~mem_ack;
      // MEM_WB is never held: it only feeds the register file
      stall_c[STL_MEM_WB] = 1'b0;

      case (state_q)
         ST_RUN, ST_DRAIN: begin
            if (mem_wait) begin
               stall_c[STL_PC]       = 1'b1;
               stall_c[STL_FI_ID]    = 1'b1;
               stall_c[STL_ID_EX]    = 1'b1;
               stall_c[STL_EX_MEM]   = 1'b1;
               bubble_c[BUB_MEM_WB]  = 1'b1;
               state_d               = ST_MWAIT;
               ret_d                 = (state_q == ST_DRAIN) && halt_req;
               tcnt_d                = TW'(1);
            end else if (br_taken) begin
               bubble_c[BUB_FI_ID]   = 1'b1;
               bubble_c[BUB_ID_EX]   = 1'b1;
               flush_c               = 1'b1;
            end else if (load_use) begin
               stall_c[STL_PC]       = 1'b1;
               stall_c[STL_FI_ID]    = 1'b1;
               bubble_c[BUB_ID_EX]   = 1'b1;
            end

            if (state_q == ST_RUN) begin
               if (!mem_wait && halt_req) begin
                  state_d = ST_DRAIN;
               end
            end else begin
               // fetch is suppressed while draining unless a branch redirects the PC
               if (!flush_c) begin
                  stall_c[STL_PC]     = 1'b1;
                  bubble_c[BUB_FI_ID] = 1'b1;
               end
               if (!halt_req) begin
                  dcnt_d = '0;
                  if (!mem_wait) begin
                     state_d = ST_RUN;
                  end
               end else if (!mem_wait) begin
                  if (dcnt_q == DR_END) begin
                     state_d = ST_HALT;
                     dcnt_d  = '0;
                  end else begin
                     dcnt_d  = dcnt_q + DW'(1);
                  end
               end
            end
         end

         ST_MWAIT: begin
            if (!mem_wait) begin
               state_d = ret_q ? ST_DRAIN : ST_RUN;
               tcnt_d  = '0;
            end else if (tcnt_q >= TO_MAX) begin
               bubble_c[BUB_MEM_WB] = 1'b1;
               mem_err_d            = 1'b1;
               state_d              = ret_q ? ST_DRAIN : ST_RUN;
               tcnt_d               = '0;
            end else begin
               stall_c[STL_PC]      = 1'b1;
               stall_c[STL_FI_ID]   = 1'b1;
               stall_c[STL_ID_EX]   = 1'b1;
               stall_c[STL_EX_MEM]  = 1'b1;
               bubble_c[BUB_MEM_WB] = 1'b1;
               tcnt_d               = tcnt_q + TW'(1);
            end
         end

         ST_HALT: begin
            stall_c[STL_PC]     = 1'b1;
            bubble_c[BUB_FI_ID] = 1'b1;
            if (!halt_req) begin
               state_d = ST_RUN;
            end
         end

         default: begin
            state_d = ST_RUN;
         end
      endcase

      halt_ack_d = (state_d == ST_HALT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_RUN;
         ret_q      <= 1'b0;
         tcnt_q     <= '0;
         dcnt_q     <= '0;
         halt_ack_q <= 1'b0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ret_q      <= ret_d;
         tcnt_q     <= tcnt_d;
         dcnt_q     <= dcnt_d;
         halt_ack_q <= halt_ack_d;
         mem_err_q  <= mem_err_d;
      end
   end

   // Everything is frozen and zeroed for as long as reset is held
   assign stall    = rst ? stall_c  : 5'b11111;
   assign bubble   = rst ? bubble_c : 4'b1111;
   assign halt_ack = halt_ack_q;
   assign mem_err  = mem_err_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [31:0] perf_flush_q, perf_flush_d;

   always_comb begin
      perf_stall_d = perf_stall_q;
      perf_flush_d = perf_flush_q;
      if ((|stall_c) && (perf_stall_q != 32'hFFFF_FFFF)) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end
      if (flush_c && (perf_flush_q != 32'hFFFF_FFFF)) begin
         perf_flush_d = perf_flush_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_flush_q <= perf_flush_d;
      end
   end

   assign perf_stall_cyc = perf_stall_q;
   assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

`default_nettype wire
